alu_hs_div: RTL and testbench
=============================

Name: alu_hs_div

Overview:
- Parametrised, handshaked successor to the team's single-cycle unsigned ALU.
- Accepts operand/opcode transactions on a valid/ready input interface and returns results on a valid/ready output interface with ZERO/ERR flags.
- Division is iterative (one quotient bit per cycle) and returns both quotient and remainder; shifts take a variable amount.
- Sits between the register-file/control FSM and the result-capture logic in the system clock domain.

Parameters:
- DATA_IN_WIDTH, 8, operand width W; legal range 2..32.
- OP_CODE_WIDTH, 4, opcode width; only 4 is supported.
- DATA_OUT_WIDTH, 2*DATA_IN_WIDTH, result width; derived, not overridable.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  operands and opcode are valid.
- IN_READY  out  1  the block accepts a transaction this cycle.
- A  in  W  operand A, unsigned.
- B  in  W  operand B, unsigned.
- ALU_FUN  in  4  opcode.
- ALU_OUT  out  2W  result.
- OUT_VALID  out  1  ALU_OUT and the flags are valid.
- OUT_READY  in  1  the consumer takes the result.
- ZERO  out  1  ALU_OUT == 0; qualified by OUT_VALID.
- ERR  out  1  divide-by-zero or illegal opcode; qualified by OUT_VALID.

Behaviour:
- One clock. Reset is synchronous and active-high: when RST=1 at a CLK edge, state goes to IDLE, any in-flight division is aborted, and ALU_OUT=0, OUT_VALID=0, ZERO=0, ERR=0. IN_READY=0 while RST=1.
- Accept: the transaction is accepted when IN_VALID && IN_READY at an edge.
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
  - A, B and ALU_FUN are captured on accept.
- Output handshake:
  - OUT_VALID stays high, with ALU_OUT/ZERO/ERR stable, until OUT_VALID && OUT_READY at an edge.
  - If no new result is produced on that edge, OUT_VALID drops.
- States: IDLE, DIV.
  - IDLE to DIV: accept with ALU_FUN=0011 and B!=0.
  - DIV to IDLE: after W iteration cycles; the result is registered and OUT_VALID=1 on that same edge.
- Latency, counted from the accept edge to the edge where OUT_VALID rises:
  - 1 cycle for all non-divide ops and for divide-by-zero.
  - W+1 cycles for a divide with B!=0.
- Throughput: back-to-back non-divide ops run at 1 per cycle while OUT_READY=1. On the edge where the held result is consumed and a new op is accepted, OUT_VALID stays 1 and carries the new result.
- Opcodes (operands zero-extended to 2W; results are modulo 2^(2W)):
  - 0000: A+B.
  - 0001: A-B; wraps two's-complement in 2W bits.
  - 0010: A*B.
  - 0011: {remainder[W-1:0], quotient[W-1:0]}.
  - 0100: A&B.
  - 0101: A|B.
  - 0110: ~(A&B); upper W bits are 0.
  - 0111: ~(A|B); upper W bits are 0.
  - 1000: A^B.
  - 1001: ~(A^B); upper W bits are 0.
  - 1010: 1 if A==B, else 0.
  - 1011: 2 if A>B, else 0.
  - 1100: 3 if A<B, else 0.
  - 1101: A >> B[$clog2(W)-1:0].
  - 1110: A << B[$clog2(W)-1:0]; upper bits are retained in 2W.
  - 1111: illegal; ALU_OUT=0, ERR=1.
- Divide-by-zero (0011 with B==0): no DIV state entered. ALU_OUT={A, W'all-ones}, ERR=1, latency 1.
- Divider: restoring algorithm, MSB first. Exactly W iteration cycles regardless of operand values; no early termination.
- Inputs while in DIV, or while blocked by backpressure, are ignored (IN_READY=0).
- Reset asserted mid-DIV discards the partial result; no OUT_VALID is produced for that transaction.
- ZERO is computed from the final registered ALU_OUT, including the illegal-opcode case (ZERO=1, ERR=1).

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_ILL (4'b0000..4'b1111);
  - state encoding for IDLE/DIV.
- One sub-module: serial_divider (W-parameterised).
  - Ports: start, dividend, divisor, busy, done, quotient, remainder.
  - Synchronous active-high reset shared with the top.
- The top holds the handshake, the opcode mux and the output registers.

Test Plan:
- W=8, ADD A=8'hFF B=8'h01, OUT_READY=1 -> ALU_OUT=16'h0100, ZERO=0, ERR=0, OUT_VALID 1 cycle after accept; SUB A=3 B=5 -> 16'hFFFE.
- DIV A=200 B=7 -> ALU_OUT=16'h041C (rem 4, quot 28), OUT_VALID 9 cycles after accept, IN_READY=0 throughout.
- DIV A=5 B=0 -> ALU_OUT=16'h05FF, ERR=1, latency 1; opcode 1111 -> ALU_OUT=0, ZERO=1, ERR=1.
- Stream 4 AND ops with IN_VALID=1 and OUT_READY=1 -> one result per cycle, in order, OUT_VALID continuously high.
- Hold OUT_READY=0 for 5 cycles after a result -> ALU_OUT stable, IN_READY=0. Release -> result consumed once, next op accepted on the same edge.
- Assert RST at cycle 4 of a DIV -> next cycle all outputs 0 and state IDLE. A subsequent SHL A=8'h81 B=3 -> ALU_OUT=16'h0408.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU with serial divider:
// opcode encodings and the controller state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_hs_div_divider.sv
// Restoring serial divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst (sync, active-high), start, dividend, divisor,
//        busy, done (last iteration cycle), quotient, remainder.
module serial_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W) + 1;

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;

    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic [W-1:0]  rem_step;
    logic [W-1:0]  quo_step;

    // One restoring step. The dividend is shifted out of the quotient
    // register MSB first while quotient bits are shifted in at the LSB.
    // diff[W] is the borrow: set when the trial subtraction goes negative.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[W]) begin
            rem_step = diff[W-1:0];
            quo_step = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_step = shifted[W-1:0];
            quo_step = {quo_q[W-2:0], 1'b0};
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    // The final step result is presented combinationally so the
    // consumer can register it on the last iteration edge.
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(W - 1));
    assign quotient  = quo_step;
    assign remainder = rem_step;

endmodule

// File: rtl/alu_hs_div.sv
// Handshaked unsigned ALU with iterative divide and ZERO/ERR flags.
// Ports: CLK, RST (sync, active-high); IN_VALID/IN_READY with A, B,
//        ALU_FUN; OUT_VALID/OUT_READY with ALU_OUT, ZERO, ERR.
module alu_hs_div
    import alu_pkg::*;
#(
    parameter int DATA_IN_WIDTH = 8,
    parameter int OP_CODE_WIDTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [DATA_IN_WIDTH-1:0]     A,
    input  logic [DATA_IN_WIDTH-1:0]     B,
    input  logic [OP_CODE_WIDTH-1:0]     ALU_FUN,
    output logic [2*DATA_IN_WIDTH-1:0]   ALU_OUT,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         ZERO,
    output logic                         ERR
);

    localparam int W              = DATA_IN_WIDTH;
    localparam int DATA_OUT_WIDTH = 2 * DATA_IN_WIDTH;
    localparam int DW             = DATA_OUT_WIDTH;
    localparam int SHW            = $clog2(W);

    state_t          state_q, state_d;
    logic [DW-1:0]   out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;

    logic            accept;
    logic            is_div_op;
    logic            div_start;
    logic            div_busy;
    logic            div_done;
    logic [W-1:0]    div_quo;
    logic [W-1:0]    div_rem;

    logic [DW-1:0]   a_x;
    logic [DW-1:0]   b_x;
    logic [SHW-1:0]  sh;
    logic [DW-1:0]   op_res;
    logic            op_err;

    assign a_x       = {{W{1'b0}}, A};
    assign b_x       = {{W{1'b0}}, B};
    assign sh        = B[SHW-1:0];
    assign is_div_op = (ALU_FUN == OP_DIV) && (B != '0);

    // Single-cycle results. The OP_DIV arm only matters for B == 0;
    // a nonzero divisor goes to the serial divider instead.
    always_comb begin
        op_res = '0;
        op_err = 1'b0;
        case (ALU_FUN)
            OP_ADD:  op_res = a_x + b_x;
            OP_SUB:  op_res = a_x - b_x;
            OP_MUL:  op_res = a_x * b_x;
            OP_DIV: begin
                op_res = {A, {W{1'b1}}};
                op_err = 1'b1;
            end
            OP_AND:  op_res = a_x & b_x;
            OP_OR:   op_res = a_x | b_x;
            OP_NAND: op_res = {{W{1'b0}}, ~(A & B)};
            OP_NOR:  op_res = {{W{1'b0}}, ~(A | B)};
            OP_XOR:  op_res = a_x ^ b_x;
            OP_XNOR: op_res = {{W{1'b0}}, ~(A ^ B)};
            OP_EQ:   op_res = (A == B) ? DW'(1) : '0;
            OP_GT:   op_res = (A > B) ? DW'(2) : '0;
            OP_LT:   op_res = (A < B) ? DW'(3) : '0;
            OP_SHR:  op_res = a_x >> sh;
            OP_SHL:  op_res = a_x << sh;
            OP_ILL:  op_err = 1'b1;
            default: op_err = 1'b1;
        endcase
    end

    serial_divider #(
        .W (W)
    ) u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (div_start),
        .dividend  (A),
        .divisor   (B),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving DIV when the divider is unexpectedly idle keeps the
    // controller from hanging if the two ever disagree.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_div_op) state_d = ST_DIV;
            ST_DIV:  if (div_done || !div_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A held result must be consumed on the same edge a new op enters,
    // so a new result can overwrite it without OUT_VALID dropping.
    always_comb begin
        IN_READY    = !RST && (state_q == ST_IDLE)
                      && (!out_valid_q || OUT_READY);
        accept      = IN_VALID && IN_READY;
        div_start   = accept && is_div_op;
        out_d       = out_q;
        zero_d      = zero_q;
        err_d       = err_q;
        out_valid_d = out_valid_q && !OUT_READY;
        if (accept && !is_div_op) begin
            out_d       = op_res;
            zero_d      = (op_res == '0);
            err_d       = op_err;
            out_valid_d = 1'b1;
        end else if ((state_q == ST_DIV) && div_done) begin
            out_d       = {div_rem, div_quo};
            zero_d      = ({div_rem, div_quo} == '0);
            err_d       = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign ALU_OUT   = out_q;
    assign OUT_VALID = out_valid_q;
    assign ZERO      = zero_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_alu_hs_div.sv
// Scoreboard bench for alu_hs_div: a driver pushes expected results
// from a plain-arithmetic model; a monitor checks each DUT output.
module tb_alu_hs_div;

    localparam int W  = 8;
    localparam int DW = 2 * W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    ALU_FUN = '0;
    logic [DW-1:0] ALU_OUT;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic          ZERO;
    logic          ERR;

    alu_hs_div #(
        .DATA_IN_WIDTH (W),
        .OP_CODE_WIDTH (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ZERO      (ZERO),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] out;
        logic          zero;
        logic          err;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   seen   = 1'b0;
    bit   rand_rdy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        longint unsigned ua, ub, r, wm, om;
        ua = 64'(a);
        ub = 64'(b);
        wm = (64'd1 << W) - 1;
        om = (64'd1 << DW) - 1;
        e.err = 1'b0;
        case (f)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua * ub;
            4'd3: begin
                if (ub == 0) begin
                    r = (ua << W) | wm;
                    e.err = 1'b1;
                end else begin
                    r = ((ua % ub) << W) | (ua / ub);
                end
            end
            4'd4:  r = ua & ub;
            4'd5:  r = ua | ub;
            4'd6:  r = ~(ua & ub) & wm;
            4'd7:  r = ~(ua | ub) & wm;
            4'd8:  r = ua ^ ub;
            4'd9:  r = ~(ua ^ ub) & wm;
            4'd10: r = (ua == ub) ? 1 : 0;
            4'd11: r = (ua > ub) ? 2 : 0;
            4'd12: r = (ua < ub) ? 3 : 0;
            4'd13: r = ua >> (ub % W);
            4'd14: r = ua << (ub % W);
            default: begin
                r = 0;
                e.err = 1'b1;
            end
        endcase
        r = r & om;
        e.out  = r[DW-1:0];
        e.zero = (r == 0);
        e.due  = 0;
        return e;
    endfunction

    // Inputs change #1 after the rising edge; acceptance is judged at
    // the falling edge, so the expectation is queued before the edge.
    task automatic send(input logic [3:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        exp_t e;
        int   n;
        bit   done;
        n = 0;
        done = 1'b0;
        ALU_FUN  = f;
        A        = a;
        B        = b;
        IN_VALID = 1'b1;
        while (!done) begin
            @(negedge CLK);
            if (IN_READY) begin
                e = model(f, a, b);
                e.due = cyc + (((f == 4'd3) && (b != 0)) ? W + 1 : 1);
                sb.push_back(e);
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout: op %0h not accepted", f);
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (OUT_VALID && !OUT_READY)
                chk("in_ready_blocked", IN_READY, 0);
            if (OUT_VALID) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h, expected none",
                             ALU_OUT);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    chk("alu_out", ALU_OUT, sb[0].out);
                    chk("zero", ZERO, sb[0].zero);
                    chk("err", ERR, sb[0].err);
                    if (OUT_READY) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                checks++;
                fails++;
                $display("FAIL missing_out: got none, expected %0h",
                         sb[0].out);
            end
        end
    end

    initial begin
        int n;
        logic [3:0]   f;
        logic [W-1:0] a, b;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_alu_out", ALU_OUT, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_zero", ZERO, 0);
        chk("rst_err", ERR, 0);
        chk("rst_in_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        OUT_READY = 1'b1;

        send(4'd0, 8'hFF, 8'h01);
        send(4'd1, 8'd3, 8'd5);

        send(4'd3, 8'd200, 8'd7);
        fork
            send(4'd0, 8'd1, 8'd2);
            begin
                for (int i = 0; i < W; i++) begin
                    @(negedge CLK);
                    chk("div_in_ready", IN_READY, 0);
                end
            end
        join

        send(4'd3, 8'd5, 8'd0);
        send(4'd15, 8'h12, 8'h34);

        for (int i = 0; i < 4; i++)
            send(4'd4, W'($urandom), W'($urandom));

        send(4'd5, 8'h0F, 8'hA0);
        OUT_READY = 1'b0;
        fork
            send(4'd8, 8'h5A, 8'h3C);
            begin
                repeat (5) @(posedge CLK);
                #1;
                OUT_READY = 1'b1;
            end
        join
        repeat (2) @(posedge CLK);
        #1;

        send(4'd3, 8'd250, 8'd3);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        sb.delete();
        seen = 1'b0;
        @(negedge CLK);
        chk("mid_rst_in_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        chk("mid_rst_alu_out", ALU_OUT, 0);
        chk("mid_rst_out_valid", OUT_VALID, 0);
        chk("mid_rst_zero", ZERO, 0);
        chk("mid_rst_err", ERR, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_in_ready", IN_READY, 1);
        repeat (W + 2) @(posedge CLK);
        #1;
        send(4'd14, 8'h81, 8'd3);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
            f = 4'($urandom_range(0, 15));
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = a;
                default: ;
            endcase
            send(f, a, b);
        end

        rand_rdy = 1'b0;
        OUT_READY = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0",
                     sb.size());
        end
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
